seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the single 4-digit seven-segment display between NREQ independent requesters, such as the combo-lock state, the entered code and the debug counter. It grants the display to one requester at a time using round-robin order with a guaranteed minimum hold time. The granted requester's four nibbles are registered onto disp3..disp0 of the existing seven-segment driver, and a blank flag is raised when nobody owns the display.

Parameters:
NREQ, 3, number of requesters; legal range 2..8.
HOLD, 4, minimum ownership in clk cycles before a contended grant may move; legal range >= 1. Use 4 for simulation and about 50_000_000 for hardware.
CW, $clog2(HOLD+1), hold counter width (derived; not overridden).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
req  input  NREQ  level request per requester; bit i is held high while requester i wants the display.
reqData  input  16*NREQ  packed display data; bits [16i+15:16i] belong to requester i, nibble order {d3,d2,d1,d0}.
gnt  output  NREQ  registered one-hot grant; all zero when idle.
disp3  output  4  registered digit 3 of the owner.
disp2  output  4  registered digit 2 of the owner.
disp1  output  4  registered digit 1 of the owner.
disp0  output  4  registered digit 0 of the owner.
blank  output  1  1 when no owner; downstream forces all segments off.

Behaviour:
- Reset (rst=0, async): gnt=0, disp3..disp0=0, blank=1, state=IDLE, holdCnt=0, last=NREQ-1. With last=NREQ-1, req[0] has first priority after reset. Reset mid-ownership drops the grant in the same instant.
- States: IDLE (no owner) and OWN (owner = index of the set gnt bit).
- Round-robin pick: the first set req bit scanning from last+1 upward, wrapping modulo NREQ. `last` updates to the new owner on every grant.
- IDLE:
  - Any req set -> OWN with gnt=pick on the next edge, holdCnt=0, blank=0. Latency from req rise to gnt is 1 cycle.
  - No req -> stay in IDLE.
- OWN, evaluated each edge in this priority order:
  1. Owner's req=0 -> release. If another req is set, grant the RR pick (excluding the owner) on the next edge with holdCnt=0 and no idle gap. Otherwise go to IDLE: gnt=0, blank=1.
  2. holdCnt==HOLD and another req is set -> switch to the RR pick, holdCnt=0.
  3. Otherwise keep the owner. holdCnt increments and saturates at HOLD.
- Drop versus expiry in the same cycle: rule 1 wins. The outcome is the same grant target, so there is no glitch.
- HOLD=1: under full contention the grant rotates every 2 cycles (1 cycle counted, then switch).
- Display path:
  - Each edge while in OWN (including the grant edge), disp3..disp0 <= the current owner's reqData slice.
  - Owner data changes appear 1 cycle later.
  - On a switch, the new owner's data appears on the same edge that gnt changes.
  - Entering IDLE: disp3..disp0 <= 0 and blank=1 on the same edge.
- gnt is always one-hot or zero. An owner is never granted while its req is low at the sampling edge.
- Requests that rise and fall while another requester owns the display are not remembered (level-sensitive, no queuing).

Test Plan:
1. Reset and first grant: hold rst=0, check gnt=000 and blank=1. Release rst, set req=001 with reqData[15:0]=16'h1234. One edge later: gnt=001, blank=0, {disp3..disp0}=1,2,3,4.
2. Round-robin under contention (HOLD=4): set req=111 with data 16'hAAAA, 16'hBBBB, 16'hCCCC for requesters 0..2. Required grant sequence: 001 for 5 cycles, then 010 for 5, then 100 for 5, then 001. Disp nibbles follow A, B, C in step with gnt.
3. Early release: requester 1 owns with holdCnt=1 and req=011. Drop req[1]. On the next edge gnt=001 and disp shows requester 0's data, with no blank cycle.
4. Uncontended hold and idle: req=100 only. gnt stays at 100 well past HOLD, with holdCnt saturated at 4. Drop req[2]: the next edge gives gnt=000, disp=0, blank=1.
5. Live update and simultaneous drop at expiry: change the owner's data from 16'h0001 to 16'h0009 mid-hold; disp0 shows 9 one cycle later. At holdCnt==HOLD, drop the owner's req while another req is set; the grant goes to the RR pick with holdCnt=0.
6. Reset mid-ownership: assert rst=0 between clock edges while gnt=010. gnt=000, disp=0 and blank=1 immediately. After release with req=110, the first grant goes to requester 1 (last=NREQ-1 restored).

Source files
------------

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner arbiter for the shared 4-digit seven-segment display
// Grants one requester at a time with a minimum hold, and registers that owner's nibbles onto disp3..disp0.
module seg_display_arbiter #(
    parameter int NREQ = 3,
    parameter int HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   reqData,
    output logic [NREQ-1:0]      gnt,
    output logic [3:0]           disp3,
    output logic [3:0]           disp2,
    output logic [3:0]           disp1,
    output logic [3:0]           disp0,
    output logic                 blank
);
    localparam int CW = $clog2(HOLD + 1);
    localparam int LW = $clog2(NREQ);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   last, last_n;
    logic [CW-1:0]   hold_cnt, hold_cnt_n;
    logic [NREQ-1:0] owner_mask, others, gnt_n;
    logic [15:0]     data_n;

    // First set bit of m scanning upward from from+1, wrapping modulo NREQ.
    function automatic logic [LW-1:0] rr_pick(input logic [NREQ-1:0] m, input logic [LW-1:0] from);
        logic found;
        int   idx;
        rr_pick = from;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(from) + k) % NREQ;
            if (!found && m[idx]) begin
                rr_pick = LW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // While in OWN, last is the current owner; in IDLE it is the most recent one.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            owner_mask[i] = (state == OWN) && (LW'(i) == last);
        end
        others     = req & ~owner_mask;
        state_n    = state;
        last_n     = last;
        hold_cnt_n = hold_cnt;

        if (state == IDLE) begin
            if (|req) begin
                state_n    = OWN;
                last_n     = rr_pick(req, last);
                hold_cnt_n = '0;
            end
        end else begin
            if (!req[last]) begin
                hold_cnt_n = '0;
                if (|others) begin
                    last_n = rr_pick(others, last);
                end else begin
                    state_n = IDLE;
                end
            end else if ((hold_cnt == CW'(HOLD)) && (|others)) begin
                last_n     = rr_pick(others, last);
                hold_cnt_n = '0;
            end else if (hold_cnt != CW'(HOLD)) begin
                hold_cnt_n = hold_cnt + CW'(1);
            end
        end

        data_n = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_n[i] = (state_n == OWN) && (LW'(i) == last_n);
            if (gnt_n[i]) begin
                data_n = reqData[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= LW'(NREQ - 1);
            hold_cnt <= '0;
            gnt      <= '0;
            disp3    <= '0;
            disp2    <= '0;
            disp1    <= '0;
            disp0    <= '0;
            blank    <= 1'b1;
        end else begin
            state    <= state_n;
            last     <= last_n;
            hold_cnt <= hold_cnt_n;
            gnt      <= gnt_n;
            {disp3, disp2, disp1, disp0} <= data_n;
            blank    <= (state_n != OWN);
        end
    end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - self-checking bench for seg_display_arbiter
// Vector table, directed corner sequences and a randomized run against a reference model.
module tb_seg_display_arbiter;
    localparam int NREQ = 3;
    localparam int HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [16*NREQ-1:0] reqData = '0;
    logic [NREQ-1:0]   gnt;
    logic [3:0]        disp3, disp2, disp1, disp0;
    logic              blank;

    int checks = 0;
    int errors = 0;

    int m_owner, m_last, m_hold;
    logic [NREQ-1:0] m_gnt;
    logic [15:0]     m_disp;
    logic            m_blank;

    seg_display_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .reqData(reqData), .gnt(gnt),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              rst_before;
        logic [NREQ-1:0] req;
        logic [47:0]     data;
        logic [NREQ-1:0] gnt;
        logic [15:0]     disp;
        logic            blank;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [NREQ-1:0] g, input logic [15:0] d, input logic b);
        logic [15:0] act;
        act = {disp3, disp2, disp1, disp0};
        checks++;
        if (gnt !== g || act !== d || blank !== b) begin
            errors++;
            $display("FAIL %s: got gnt=%b disp=%h blank=%b, expected gnt=%b disp=%h blank=%b",
                     name, gnt, act, blank, g, d, b);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] m, input int from);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = NREQ - 1;
        m_hold  = 0;
        m_gnt   = '0;
        m_disp  = '0;
        m_blank = 1'b1;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [47:0] d);
        logic [NREQ-1:0] others;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = rr(r, m_last);
                m_hold  = 0;
            end
        end else begin
            others = r & ~(NREQ'(1) << m_owner);
            if (!r[m_owner]) begin
                m_owner = (others != 0) ? rr(others, m_last) : -1;
                m_hold  = 0;
            end else if (m_hold == HOLD && others != 0) begin
                m_owner = rr(others, m_last);
                m_hold  = 0;
            end else begin
                m_hold = (m_hold < HOLD) ? m_hold + 1 : HOLD;
            end
        end
        if (m_owner >= 0) m_last = m_owner;
        m_gnt   = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        m_disp  = (m_owner >= 0) ? d[16*m_owner +: 16] : 16'h0;
        m_blank = (m_owner < 0);
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic [47:0] d);
        @(negedge clk);
        req     = r;
        reqData = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check("model", m_gnt, m_disp, m_blank);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst     = 1'b0;
        req     = '0;
        reqData = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", '0, 16'h0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [47:0] abc;
        logic [47:0] rd;
        logic [NREQ-1:0] rq;

        // Test 1: first grant after reset
        v = '{1'b1, 3'b001, {32'h0, 16'h1234}, 3'b001, 16'h1234, 1'b0};
        vecs.push_back(v);
        // Test 2: full contention rotates every HOLD+1 cycles
        abc = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int i = 0; i < 16; i++) begin
            v.rst_before = (i == 0);
            v.req        = 3'b111;
            v.data       = abc;
            v.blank      = 1'b0;
            case ((i / (HOLD + 1)) % 3)
                0: begin v.gnt = 3'b001; v.disp = 16'hAAAA; end
                1: begin v.gnt = 3'b010; v.disp = 16'hBBBB; end
                default: begin v.gnt = 3'b100; v.disp = 16'hCCCC; end
            endcase
            vecs.push_back(v);
        end
        v = '{1'b0, 3'b000, abc, 3'b000, 16'h0, 1'b1};
        vecs.push_back(v);

        model_reset();
        reset_dut();
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) reset_dut();
            step(vecs[i].req, vecs[i].data);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].disp, vecs[i].blank);
        end

        // Test 3: early release hands over with no blank gap
        reset_dut();
        rd = {16'h3333, 16'h2222, 16'h1111};
        step(3'b010, rd);
        check("early_grant", 3'b010, 16'h2222, 1'b0);
        step(3'b011, rd);
        step(3'b001, rd);
        check("early_release", 3'b001, 16'h1111, 1'b0);

        // Test 4: uncontended hold, then idle
        reset_dut();
        for (int i = 0; i < 3 * HOLD; i++) step(3'b100, rd);
        check("uncontended_hold", 3'b100, 16'h3333, 1'b0);
        step(3'b000, rd);
        check("to_idle", 3'b000, 16'h0, 1'b1);

        // Test 5: live data update, drop at expiry, hold counter restarts
        reset_dut();
        step(3'b001, {16'h7777, 16'h0, 16'h0001});
        check("live_before", 3'b001, 16'h0001, 1'b0);
        step(3'b001, {16'h7777, 16'h0, 16'h0009});
        check("live_after", 3'b001, 16'h0009, 1'b0);
        for (int i = 0; i < HOLD - 1; i++) step(3'b001, {16'h7777, 16'h0, 16'h0009});
        step(3'b100, {16'h7777, 16'h0, 16'h0009});
        check("drop_at_expiry", 3'b100, 16'h7777, 1'b0);
        for (int i = 0; i < HOLD; i++) step(3'b101, {16'h7777, 16'h0, 16'h0009});
        check("hold_restarted", 3'b100, 16'h7777, 1'b0);
        step(3'b101, {16'h7777, 16'h0, 16'h0009});
        check("switch_after_hold", 3'b001, 16'h0009, 1'b0);

        // Test 6: asynchronous reset mid-ownership
        reset_dut();
        step(3'b010, rd);
        check("pre_async", 3'b010, 16'h2222, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_reset", 3'b000, 16'h0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        step(3'b110, rd);
        check("post_reset_pick", 3'b010, 16'h2222, 1'b0);

        // Randomized run against the reference model
        reset_dut();
        rq = '0;
        rd = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom());
            if ($urandom_range(0, 2) == 0) rd = {16'($urandom()), 16'($urandom()), 16'($urandom())};
            step(rq, rd);
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL onehot: got gnt=%b, expected one-hot or zero", gnt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
